// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded register file:
//   - default register width and address width of the core's register file
//   - address/data typedefs at the default widths
//   - count_w(): width of the busy counter, wide enough to hold DEPTH itself
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 19;
    localparam int ADDR_W_DEF = 4;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // A counter of DEPTH = 2**addr_w busy bits must represent DEPTH itself,
    // so it needs one bit more than the address.
    function automatic int count_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_sb_score.sv
// -----------------------------------------------------------------------------
// regfile_sb_score
// Busy-bit scoreboard of the register file. Decode reserves a destination,
// writeback releases it.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   wr_en, wr_addr  writeback strobe/address (clears busy)
//   rsv_en,rsv_addr reservation request (sets busy when granted)
//   busy            raw busy vector, one bit per register
//   rsv_grant       combinational: reservation accepted this cycle
//   busy_count      registered popcount of busy
// -----------------------------------------------------------------------------
module regfile_sb_score
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [(1<<ADDR_W)-1:0]     busy,
    output logic                       rsv_grant,
    output logic [count_w(ADDR_W)-1:0] busy_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = count_w(ADDR_W);

    logic             rsv_is_zero;
    logic             set_en;
    logic             clr_en;
    logic             inc;
    logic             dec;
    logic [DEPTH-1:0] busy_next;

    assign rsv_is_zero = (ZERO_REG != 0) && (rsv_addr == '0);

    // A busy destination can still be granted when its writeback lands in the
    // same cycle: the old producer retires as the new one is issued.
    assign rsv_grant = rsv_en && (!busy[rsv_addr] || (wr_en && wr_addr == rsv_addr));

    // The hard-wired zero register is granted but never tracked.
    assign set_en = rsv_grant && !rsv_is_zero;

    // Register 0 is never busy under ZERO_REG, so a writeback there never clears.
    assign clr_en = wr_en && busy[wr_addr];

    // set_en on a busy register only happens together with its own clearing
    // writeback, so that case nets to zero on both sides.
    assign inc = set_en && !busy[rsv_addr];
    assign dec = clr_en && !(set_en && rsv_addr == wr_addr);

    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path
        // leaves it unassigned and a latch is never inferred.
        busy_next = busy;
        if (clr_en) busy_next[wr_addr] = 1'b0;
        // Applied after the clear so a same-address reserve wins.
        if (set_en) busy_next[rsv_addr] = 1'b1;
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count + CNT_W'(inc) - CNT_W'(dec);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with two combinational read ports, one writeback port,
// optional write-to-read bypass, optional hard-wired zero register and a
// per-register busy scoreboard for hazard checking.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rd_addr1/2               read addresses
//   rd_data1/2, rd_busy1/2   combinational read data and busy bit
//   wr_en, wr_addr, wr_data  writeback
//   rsv_en, rsv_addr         destination reservation request
//   rsv_grant                combinational reservation accept
//   busy_count               registered number of busy registers
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic [DATA_W-1:0]          rd_data1,
    output logic [DATA_W-1:0]          rd_data2,
    output logic                       rd_busy1,
    output logic                       rd_busy2,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rsv_grant,
    output logic [count_w(ADDR_W)-1:0] busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_commit;
    logic              hit1;
    logic              hit2;

    regfile_sb_score #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_score (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy       (busy),
        .rsv_grant  (rsv_grant),
        .busy_count (busy_count)
    );

    assign wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // NOTE: the array is reset because the architectural state must read 0
    // straight out of reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-cycle writeback match for each read port (only when bypassing).
    assign hit1 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1);
    assign hit2 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2);

    // Zero register beats bypass: a write to r0 must never become visible.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              hit
    );
        if ((ZERO_REG != 0) && (addr == '0)) return '0;
        if (hit)                             return wr_data;
        return stored;
    endfunction

    assign rd_data1 = read_mux(rd_addr1, mem[rd_addr1], hit1);
    assign rd_data2 = read_mux(rd_addr2, mem[rd_addr2], hit2);

    // A forwarded writeback retires the producer, so the operand is ready.
    assign rd_busy1 = busy[rd_addr1] && !hit1;
    assign rd_busy2 = busy[rd_addr2] && !hit2;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Drives three register files from one stimulus stream:
//   [0] defaults (no zero register, bypass), [1] bypass off, [2] zero register.
// A directed vector table and hand sequences cover the documented scenarios;
// random traffic is compared against an array-based model of the register
// contents and busy set.
// -----------------------------------------------------------------------------
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW    = DATA_W_DEF;
    localparam int AW    = ADDR_W_DEF;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = count_w(AW);
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_addr_t rd_addr1, rd_addr2, wr_addr, rsv_addr;
    reg_data_t wr_data;
    logic      wr_en, rsv_en;

    logic [NDUT-1:0][DW-1:0] d1, d2;
    logic [NDUT-1:0]         b1, b2, g;
    logic [NDUT-1:0][CW-1:0] cnt;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1[0]), .rd_data2(d2[0]), .rd_busy1(b1[0]), .rd_busy2(b2[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_grant(g[0]), .busy_count(cnt[0]));

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1[1]), .rd_data2(d2[1]), .rd_busy1(b1[1]), .rd_busy2(b2[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_grant(g[1]), .busy_count(cnt[1]));

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1[2]), .rd_data2(d2[2]), .rd_busy1(b1[2]), .rd_busy2(b2[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_grant(g[2]), .busy_count(cnt[2]));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Model set 0: no zero register (DUTs 0 and 1); set 1: zero register (DUT 2).
    reg_data_t m_reg  [2][DEPTH];
    bit        m_busy [2][DEPTH];

    function automatic int set_of(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    function automatic bit byp_of(input int i);
        return (i != 1);
    endfunction

    function automatic reg_data_t m_rd(input int i, input reg_addr_t a);
        int s = set_of(i);
        if (s == 1 && a == 0) return '0;
        if (byp_of(i) && wr_en && wr_addr == a) return wr_data;
        return m_reg[s][a];
    endfunction

    function automatic bit m_busy_rd(input int i, input reg_addr_t a);
        int s = set_of(i);
        if (byp_of(i) && wr_en && wr_addr == a) return 1'b0;
        return m_busy[s][a];
    endfunction

    function automatic bit m_grant(input int s);
        return rsv_en && (!m_busy[s][rsv_addr] || (wr_en && wr_addr == rsv_addr));
    endfunction

    function automatic int m_count(input int i);
        int c = 0;
        for (int k = 0; k < DEPTH; k++) c += int'(m_busy[set_of(i)][k]);
        return c;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < DEPTH; k++) begin
                m_reg[s][k]  = '0;
                m_busy[s][k] = 1'b0;
            end
    endtask

    task automatic m_step();
        for (int s = 0; s < 2; s++) begin
            bit gr = m_grant(s);
            if (wr_en && !(s == 1 && wr_addr == 0)) begin
                m_reg[s][wr_addr]  = wr_data;
                m_busy[s][wr_addr] = 1'b0;
            end
            if (gr && !(s == 1 && rsv_addr == 0)) m_busy[s][rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_comb();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("model d1[%0d] a=%0d", i, rd_addr1), 32'(d1[i]), 32'(m_rd(i, rd_addr1)));
            check($sformatf("model d2[%0d] a=%0d", i, rd_addr2), 32'(d2[i]), 32'(m_rd(i, rd_addr2)));
            check($sformatf("model b1[%0d]", i), 32'(b1[i]), 32'(m_busy_rd(i, rd_addr1)));
            check($sformatf("model b2[%0d]", i), 32'(b2[i]), 32'(m_busy_rd(i, rd_addr2)));
            check($sformatf("model grant[%0d]", i), 32'(g[i]), 32'(m_grant(set_of(i))));
        end
    endtask

    // Advance one edge; the model consumes the same inputs the DUTs sample.
    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("model count[%0d]", i), 32'(cnt[i]), 32'(m_count(i)));
    endtask

    task automatic apply(input logic we, input reg_addr_t wa, input reg_data_t wd,
                         input logic re, input reg_addr_t ra,
                         input reg_addr_t a1, input reg_addr_t a2);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd_addr1 = a1; rd_addr2 = a2;
        #1;
    endtask

    // ---------------- directed vectors (DUT 0: defaults) ----------------
    typedef struct {
        logic      we;  reg_addr_t wa; reg_data_t wd;
        logic      re;  reg_addr_t ra;
        reg_addr_t a1;  reg_addr_t a2;
        reg_data_t e_d1; reg_data_t e_d2;
        logic      e_b1; logic e_b2; logic e_g;
        int        e_cnt;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    initial begin
        int cz;

        //          we wa wd       re ra a1 a2 e_d1     e_d2     b1 b2 g  cnt
        vecs[0]  = '{1, 1, 25,      0, 0, 1, 2, 25,      0,       0, 0, 0, 0};
        vecs[1]  = '{1, 2, 50,      0, 0, 1, 2, 25,      50,      0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0,       0, 0, 1, 2, 25,      50,      0, 0, 0, 0};
        vecs[3]  = '{1, 3, 'h7FFFF, 0, 0, 3, 1, 'h7FFFF, 25,      0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0,       1, 4, 4, 3, 0,       'h7FFFF, 0, 0, 1, 1};
        vecs[5]  = '{0, 0, 0,       1, 4, 4, 3, 0,       'h7FFFF, 1, 0, 0, 1};
        vecs[6]  = '{1, 4, 9,       0, 0, 4, 4, 9,       9,       0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0,       0, 0, 4, 0, 9,       0,       0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0,       1, 5, 5, 4, 0,       9,       0, 0, 1, 1};
        vecs[9]  = '{1, 5, 11,      1, 5, 5, 5, 11,      11,      0, 0, 1, 1};
        vecs[10] = '{0, 0, 0,       0, 0, 5, 4, 11,      9,       1, 0, 0, 1};
        vecs[11] = '{1, 6, 3,       1, 7, 5, 6, 11,      3,       1, 0, 1, 2};
        vecs[12] = '{1, 5, 1,       1, 6, 6, 5, 3,       1,       0, 0, 1, 2};
        vecs[13] = '{0, 0, 0,       0, 0, 6, 5, 3,       1,       1, 0, 0, 2};

        // Reset
        rst = 1'b0;
        m_reset();
        apply(0, 0, 0, 0, 0, 0, 0);
        #10;
        check("reset count", 32'(cnt[0]), 0);
        check("reset d1", 32'(d1[0]), 0);
        check("reset b1", 32'(b1[0]), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Bypass on vs off, same cycle as the write
        apply(1, 3, 'h7FFFF, 0, 0, 3, 3);
        check("bypass on d1", 32'(d1[0]), 32'h7FFFF);
        check("bypass off d1", 32'(d1[1]), 0);
        check_comb();
        tick();
        apply(0, 0, 0, 0, 0, 3, 3);
        check("bypass off after edge", 32'(d1[1]), 32'h7FFFF);
        check_comb();

        // Directed table
        for (int v = 0; v < NVEC; v++) begin
            apply(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re, vecs[v].ra, vecs[v].a1, vecs[v].a2);
            check($sformatf("vec%0d d1", v), 32'(d1[0]), 32'(vecs[v].e_d1));
            check($sformatf("vec%0d d2", v), 32'(d2[0]), 32'(vecs[v].e_d2));
            check($sformatf("vec%0d b1", v), 32'(b1[0]), 32'(vecs[v].e_b1));
            check($sformatf("vec%0d b2", v), 32'(b2[0]), 32'(vecs[v].e_b2));
            check($sformatf("vec%0d grant", v), 32'(g[0]), 32'(vecs[v].e_g));
            check_comb();
            tick();
            check($sformatf("vec%0d count", v), 32'(cnt[0]), 32'(vecs[v].e_cnt));
        end

        // Zero register: write ignored, reserve granted but never busy
        apply(1, 0, 99, 0, 0, 0, 0);
        check("zero read during write", 32'(d1[2]), 0);
        check("no-zero bypass r0", 32'(d1[0]), 99);
        check_comb();
        tick();
        cz = int'(cnt[2]);
        apply(0, 0, 0, 1, 0, 0, 0);
        check("zero read after write", 32'(d1[2]), 0);
        check("zero rsv grant", 32'(g[2]), 1);
        check_comb();
        tick();
        check("zero rsv count unchanged", 32'(cnt[2]), 32'(cz));
        check("zero never busy", 32'(b1[2]), 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 1)), reg_addr_t'($urandom), reg_data_t'($urandom),
                  1'($urandom_range(0, 9) < 6), reg_addr_t'($urandom),
                  reg_addr_t'($urandom), reg_addr_t'($urandom));
            check_comb();
            tick();
        end

        // Fill everything, then reset between edges
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, reg_addr_t'(i), reg_data_t'(i * 3 + 1), 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 0, 0, 1, reg_addr_t'(i), reg_addr_t'(i), 0);
            check($sformatf("fill grant r%0d", i), 32'(g[0]), 1);
            tick();
        end
        check("full count", 32'(cnt[0]), 16);
        check("full count nb", 32'(cnt[1]), 16);
        check("full count zero", 32'(cnt[2]), 15);
        apply(0, 0, 0, 0, 0, 1, 2);
        check("pre-reset d1 r1", 32'(d1[0]), 4);
        check("pre-reset b1 r1", 32'(b1[0]), 1);

        rst = 1'b0;
        m_reset();
        #1;
        // Still before the next rising edge.
        for (int i = 0; i < NDUT; i++)
            check($sformatf("async reset count[%0d]", i), 32'(cnt[i]), 0);
        check("async reset d1 r1", 32'(d1[0]), 0);
        check("async reset b1 r1", 32'(b1[0]), 0);
        check("async reset d2 r2", 32'(d2[0]), 0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr1 = reg_addr_t'(a);
            rd_addr2 = reg_addr_t'(DEPTH - 1 - a);
            #1;
            check($sformatf("reset sweep d1 r%0d", a), 32'(d1[0]), 0);
            check($sformatf("reset sweep b1 r%0d", a), 32'(b1[0]), 0);
            check($sformatf("reset sweep b2 nb r%0d", DEPTH - 1 - a), 32'(b2[1]), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 50; n++) begin
            apply(1'($urandom_range(0, 1)), reg_addr_t'($urandom), reg_data_t'($urandom),
                  1'($urandom_range(0, 1)), reg_addr_t'($urandom),
                  reg_addr_t'($urandom), reg_addr_t'($urandom));
            check_comb();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
